// File: rtl/fir_p2s_quantizer.sv
// -----------------------------------------------------------------------------
// fir_p2s_quantizer
//
// Downstream stage of the 4-way parallel FIR. It accepts one frame of four
// full-precision samples per cycle. Each sample is rounded (round half up) and
// reduced to NB_DATA_OUT bits as it is written into a small frame buffer.
// Buffered frames are serialized one sample per cycle over a valid/ready stream.
// Within a frame, sample 0 is sent first.
//
// Optional feature macro: FIR_P2S_SAT_EN
//   defined   : quantized samples saturate to the NB_DATA_OUT range, and o_sat
//               is a sticky "saturation seen" flag
//   undefined : quantized samples wrap (two's complement), and o_sat is tied to 0
//
// Ports
//   clk        in   single clock, rising edge
//   i_rst      in   asynchronous, active-low reset
//   i_data_0   in   signed parallel sample 0 (oldest)
//   i_data_1   in   signed parallel sample 1
//   i_data_2   in   signed parallel sample 2
//   i_data_3   in   signed parallel sample 3 (newest)
//   i_valid    in   frame on i_data_0..3 is valid
//   o_ready    out  buffer can accept a frame this cycle (from registered count)
//   o_data     out  signed serial output sample (0 when o_valid is low)
//   o_valid    out  o_data is valid
//   i_ready    in   downstream accepts o_data this cycle
//   o_sat      out  sticky saturation flag, cleared only by reset
//
// Parameter constraints
//   NB_DATA_IN - NB_FRAC_DROP >= NB_DATA_OUT
//   NB_FRAC_DROP >= 1
//   DEPTH_FRAMES is a power of two and >= 2
// -----------------------------------------------------------------------------
module fir_p2s_quantizer #(
  parameter int NB_DATA_IN   = 19,
  parameter int NB_DATA_OUT  = 8,
  parameter int NB_FRAC_DROP = 11,
  parameter int DEPTH_FRAMES = 2
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic signed [NB_DATA_IN-1:0]  i_data_0,
  input  logic signed [NB_DATA_IN-1:0]  i_data_1,
  input  logic signed [NB_DATA_IN-1:0]  i_data_2,
  input  logic signed [NB_DATA_IN-1:0]  i_data_3,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic signed [NB_DATA_OUT-1:0] o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sat
);

  // Width of the rounded value before range limiting. One guard bit is kept
  // above the input width so that adding the rounding constant cannot overflow.
  localparam int Q_W   = NB_DATA_IN + 1 - NB_FRAC_DROP;
  localparam int PTR_W = $clog2(DEPTH_FRAMES);
  localparam int CNT_W = $clog2(DEPTH_FRAMES + 1);

  localparam logic signed [NB_DATA_IN:0] HALF =
    (NB_DATA_IN + 1)'(2 ** (NB_FRAC_DROP - 1));

`ifdef FIR_P2S_SAT_EN
  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'(2 ** (NB_DATA_OUT - 1) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN = ~Q_MAX;
  localparam logic signed [NB_DATA_OUT-1:0] OUT_MAX = {1'b0, {(NB_DATA_OUT-1){1'b1}}};
  localparam logic signed [NB_DATA_OUT-1:0] OUT_MIN = {1'b1, {(NB_DATA_OUT-1){1'b0}}};
`endif

  // Round half up. The constant 2^(NB_FRAC_DROP-1) is added at NB_DATA_IN+1
  // bits, and the result is shifted arithmetically. For negative ties this
  // rounds toward +inf (for example, -1024 -> 0).
  function automatic logic signed [Q_W-1:0] round_sample(
    input logic signed [NB_DATA_IN-1:0] x
  );
    return Q_W'(($signed({x[NB_DATA_IN-1], x}) + HALF) >>> NB_FRAC_DROP);
  endfunction

  // Reduce a rounded value to the output width.
  function automatic logic signed [NB_DATA_OUT-1:0] limit_sample(
    input logic signed [Q_W-1:0] q
  );
`ifdef FIR_P2S_SAT_EN
    if (q > Q_MAX)      return OUT_MAX;
    else if (q < Q_MIN) return OUT_MIN;
    else                return q[NB_DATA_OUT-1:0];
`else
    return q[NB_DATA_OUT-1:0];
`endif
  endfunction

`ifdef FIR_P2S_SAT_EN
  function automatic logic sample_saturates(input logic signed [Q_W-1:0] q);
    return (q > Q_MAX) || (q < Q_MIN);
  endfunction
`endif

  // Control state
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       idx;
  logic [CNT_W-1:0] count;

  // Frame buffer: holds quantized samples, and is intentionally not reset
  logic signed [NB_DATA_OUT-1:0] buf_mem [0:DEPTH_FRAMES-1][0:3];

  logic signed [NB_DATA_IN-1:0]  data_in_p0 [0:3];
  logic signed [Q_W-1:0]         q_raw_p0   [0:3];
  logic signed [NB_DATA_OUT-1:0] q_p0       [0:3];

  logic push;
  logic pop;
  logic release_frame;

  assign data_in_p0[0] = i_data_0;
  assign data_in_p0[1] = i_data_1;
  assign data_in_p0[2] = i_data_2;
  assign data_in_p0[3] = i_data_3;

  // Stage p0: quantize the incoming frame (combinational, ahead of the buffer write)
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      q_raw_p0[k] = round_sample(data_in_p0[k]);
      q_p0[k]     = limit_sample(q_raw_p0[k]);
    end
  end

  // Handshakes. o_ready depends only on the registered count, so it does not
  // depend on i_ready. As a result, a slot freed on one edge is offered only
  // on the next cycle.
  assign o_ready       = (count < CNT_W'(DEPTH_FRAMES));
  assign o_valid       = (count != '0);
  assign push          = i_valid && o_ready;
  assign pop           = o_valid && i_ready;
  assign release_frame = pop && (idx == 2'd3);

  assign o_data = o_valid ? buf_mem[rd_ptr][idx] : '0;

  // Stage p0 -> buffer: write the quantized frame at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        buf_mem[wr_ptr][k] <= q_p0[k];
      end
    end
  end

  // Pointer, sample index and occupancy. An asynchronous reset empties the
  // buffer, so any stale contents are never read afterwards.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        idx <= idx + 2'd1;
      end
      if (release_frame) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, release_frame})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIR_P2S_SAT_EN
  logic frame_sat_p0;
  logic sat_flag;

  always_comb begin
    frame_sat_p0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      frame_sat_p0 = frame_sat_p0 | sample_saturates(q_raw_p0[k]);
    end
  end

  // Sticky flag: set on the edge that writes a saturating frame
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      sat_flag <= 1'b0;
    end else if (push && frame_sat_p0) begin
      sat_flag <= 1'b1;
    end
  end

  assign o_sat = sat_flag;
`else
  assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_fir_p2s_quantizer.sv
// -----------------------------------------------------------------------------
// tb_fir_p2s_quantizer
//
// Scoreboard bench for fir_p2s_quantizer. The stimulus thread pushes
// hand-computed expected serial samples into a queue. A monitor pops the queue
// and compares on every accepted output beat (o_valid && i_ready), sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fir_p2s_quantizer;

  localparam int NB_IN  = 19;
  localparam int NB_OUT = 8;

  logic                     clk;
  logic                     i_rst;
  logic signed [NB_IN-1:0]  i_data_0;
  logic signed [NB_IN-1:0]  i_data_1;
  logic signed [NB_IN-1:0]  i_data_2;
  logic signed [NB_IN-1:0]  i_data_3;
  logic                     i_valid;
  logic                     o_ready;
  logic signed [NB_OUT-1:0] o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_sat;

  int exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  fir_p2s_quantizer #(
    .NB_DATA_IN  (NB_IN),
    .NB_DATA_OUT (NB_OUT),
    .NB_FRAC_DROP(11),
    .DEPTH_FRAMES(2)
  ) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_data_0(i_data_0),
    .i_data_1(i_data_1),
    .i_data_2(i_data_2),
    .i_data_3(i_data_3),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sat   (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every accepted beat must match the next expected sample
  always @(negedge clk) begin
    if (i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", int'(o_data), -999);
      end else begin
        check("serial_sample", int'(o_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Push one frame (bounded wait for o_ready) and queue its expected samples
  task automatic push_frame(input int a, b, c, d, input int e0, e1, e2, e3);
    int w;
    w = 0;
    while (!o_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!o_ready) check("push_wait_ready", 0, 1);
    i_data_0 = NB_IN'(a);
    i_data_1 = NB_IN'(b);
    i_data_2 = NB_IN'(c);
    i_data_3 = NB_IN'(d);
    i_valid  = 1'b1;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  int nv;

  initial begin
    i_rst    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_0 = '0;
    i_data_1 = '0;
    i_data_2 = '0;
    i_data_3 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_ready", int'(o_ready), 1);
    check("rst_o_sat", int'(o_sat), 0);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;

    // Rounding, round half up: 1024->1, -1024->0, 3072->2, -2049->-1
    i_ready = 1'b1;
    push_frame(1024, -1024, 3072, -2049, 1, 0, 2, -1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("round_valid_cycles", nv, 4);
    wait_drain("round_drain");

    // Saturation / wrap
`ifdef FIR_P2S_SAT_EN
    push_frame(262143, -262144, 262144 - 1024, 0, 127, -128, 127, 0);
    @(negedge clk);
    check("sat_rise", int'(o_sat), 1);
    wait_drain("sat_drain");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_sticky", int'(o_sat), 1);
`else
    push_frame(262143, -262144, 262144 - 1024, 0, -128, -128, -128, 0);
    @(negedge clk);
    check("wrap_no_sat", int'(o_sat), 0);
    wait_drain("wrap_drain");
    @(negedge clk);
    check("wrap_sat_still0", int'(o_sat), 0);
`endif
    @(posedge clk); #1;

    // Backpressure / full: A = 1,2,3,4 and B = -1,-2,-3,-4
    i_ready = 1'b0;
    push_frame(2048, 4096, 6144, 8192, 1, 2, 3, 4);
    push_frame(-2048, -4096, -6144, -8192, -1, -2, -3, -4);
    check("full_o_ready", int'(o_ready), 0);
    // Third frame offered while full must be dropped (quantizes to 9s)
    i_data_0 = NB_IN'(18432);
    i_data_1 = NB_IN'(18432);
    i_data_2 = NB_IN'(18432);
    i_data_3 = NB_IN'(18432);
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("full_still_not_ready", int'(o_ready), 0);
    check("stall_valid", int'(o_valid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data_hold", int'(o_data), 1);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_before_A3", int'(o_ready), 0);
    @(posedge clk);
    @(negedge clk);
    check("ready_after_A3", int'(o_ready), 1);
    wait_drain("bp_drain");
    @(negedge clk);
    check("third_frame_dropped", int'(o_valid), 0);
    @(posedge clk); #1;

    // Concurrent push/pop: one frame every 4 cycles, with gap-free output
    i_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      push_frame((4*f)*2048, (4*f+1)*2048, (4*f+2)*2048, (4*f+3)*2048,
                 4*f, 4*f+1, 4*f+2, 4*f+3);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("stream_valid", int'(o_valid), 1);
        check("stream_ready", int'(o_ready), 1);
        if (c < 2) begin
          @(posedge clk); #1;
        end
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("stream_valid_s3", int'(o_valid), 1);
    end
    wait_drain("stream_drain");

    // Asynchronous reset with two frames buffered
    i_ready = 1'b0;
    push_frame(2048, 2048, 2048, 2048, 1, 1, 1, 1);
    push_frame(4096, 4096, 4096, 4096, 2, 2, 2, 2);
    @(negedge clk);
    check("pre_rst_full", int'(o_ready), 0);
    #2;
    i_rst = 1'b0;
    #1;
    check("async_rst_o_valid", int'(o_valid), 0);
    check("async_rst_o_data", int'(o_data), 0);
    check("async_rst_o_ready", int'(o_ready), 1);
    check("async_rst_o_sat", int'(o_sat), 0);
    exp_q.delete();
    @(posedge clk); #1;
    i_rst   = 1'b1;
    i_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("no_stale_after_rst", nv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_p2s_quantizer.md
Name: fir_p2s_quantizer

Overview:
Downstream stage of the 4-way parallel FIR. Each cycle the FIR can present one frame of four full-precision outputs (19 b). This block accepts that frame and rounds and saturates each sample to NB_DATA_OUT bits. It buffers up to DEPTH_FRAMES frames and serializes them one sample per cycle over a valid/ready stream, for the downstream sample-rate converter or DAC interface.

Parameters:
NB_DATA_IN, 19, width of each signed parallel input sample (FIR output width)
NB_DATA_OUT, 8, width of each signed serial output sample
NB_FRAC_DROP, 11, LSBs discarded by rounding; constraint NB_DATA_IN - NB_FRAC_DROP >= NB_DATA_OUT
DEPTH_FRAMES, 2, frame buffer depth in 4-sample frames; power of two, >= 2

Ports:
clk  in  1  single clock, all logic on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_data_0  in  NB_DATA_IN  signed parallel sample 0 (oldest in time)
i_data_1  in  NB_DATA_IN  signed parallel sample 1
i_data_2  in  NB_DATA_IN  signed parallel sample 2
i_data_3  in  NB_DATA_IN  signed parallel sample 3 (newest)
i_valid  in  1  frame on i_data_0..3 is valid (driven by FIR enable)
o_ready  out  1  frame buffer can accept a frame this cycle
o_data  out  NB_DATA_OUT  signed serial output sample
o_valid  out  1  o_data valid
i_ready  in  1  downstream accepts o_data this cycle
o_sat  out  1  sticky: at least one sample saturated since reset

Behaviour:
- Clock and reset: one clock (clk). Reset i_rst is asynchronous and active-low.
- Reset state: write ptr, read ptr, sample index and count cleared to 0; o_valid=0, o_data=0, o_sat=0; o_ready=1 (count=0). Buffer contents need no reset.
- Reset mid-operation: all buffered frames are discarded immediately; no partial frame is emitted after release.
- o_ready = (count < DEPTH_FRAMES), combinational from registered count only; it does not depend on i_ready.
- Push: i_valid && o_ready at a rising edge writes one quantized 4-sample frame at the write ptr; write ptr wraps modulo DEPTH_FRAMES.
- i_valid while o_ready=0: frame dropped, state unchanged. The upstream must not do this; the bench flags it.
- Quantization, per sample, at write time:
  - t = x + 2^(NB_FRAC_DROP-1), computed at NB_DATA_IN+1 bits.
  - q = t >>> NB_FRAC_DROP, arithmetic shift (round half up).
  - Saturate q to [-2^(NB_DATA_OUT-1), 2^(NB_DATA_OUT-1)-1]; see Optional Feature.
- Serializer:
  - o_valid = (count != 0).
  - o_data = buffer[read ptr][index] while o_valid, else 0.
  - Order per frame: sample 0, 1, 2, 3.
- Pop handshake: o_valid && i_ready advances index.
  - At index 3: index returns to 0, read ptr advances (wrapping) and the frame is released (count decrements).
  - o_data and o_valid must hold stable while o_valid && !i_ready.
- Simultaneous push and release on the same edge: count unchanged, both pointers advance.
- Full: push and release on the same edge is impossible, because o_ready is already 0. The freed slot is visible the next cycle (no bypass).
- Latency: frame pushed at edge k → sample 0 on o_data with o_valid=1 from after edge k (count was 0). With i_ready held at 1, samples 0..3 appear on 4 consecutive cycles.
- Throughput: sustained 1 frame per 4 cycles. When upstream pushes faster, o_ready deasserts once DEPTH_FRAMES frames are held.
- o_sat sets on the edge a saturating frame is written; it is cleared only by reset.

Optional Feature:
Macro FIR_P2S_SAT_EN.
- Defined: saturation as specified; o_sat is functional.
- Undefined: no saturation; o_data takes the low NB_DATA_OUT bits of q (two's-complement wrap); o_sat tied to 0.

Test Plan:
- Reset check: assert i_rst=0 mid-stream with 2 frames buffered → o_valid=0, o_data=0, o_ready=1, o_sat=0 immediately (asynchronous); after release, no stale samples appear.
- Rounding: push frame {1024, -1024, 3072, -2049} with i_ready=1 → serial output 1, 0, 2, -1 on 4 consecutive cycles, o_valid high only for those 4 cycles.
- Saturation (SAT_EN defined): push {262143, -262144, 262144-1024, 0} → 127, -128, 127, 0; o_sat rises after the push edge and stays 1.
- Wrap (SAT_EN undefined): same frame → -128, -128, -128, 0; o_sat=0.
- Backpressure/full (DEPTH_FRAMES=2): i_ready=0, push frames A and B → o_ready=0 after the 2nd push, and a 3rd i_valid is ignored. Release i_ready → A0..A3 then B0..B3 in order, o_data stable while stalled, o_ready=1 the cycle after A3 is accepted.
- Concurrent push/pop: continuous i_ready=1, push one frame every 4 cycles aligned with release of sample 3 → count stays 1, gap-free serial stream, o_ready never deasserts.
